// File: rtl/dac_src_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dac_src_ctrl
// Description : Arbitrates DAC ownership between the DMA path and the
//               accelerator. Switching to the accelerator waits a settle
//               period before granting. Releasing it drains the FIFO and then
//               guards the switch back to DMA.
//               Optional ACC_ACT watchdog: define DAC_SRC_CTRL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_src_ctrl #(
  parameter int SETTLE_CYCLES  = 8,
  parameter int DRAIN_CYCLES   = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       acc_clk,
  input  logic       acc_rstn,
  input  logic       dma_req,
  input  logic       dma_done,
  input  logic       acc_req,
  input  logic       acc_done,
  input  logic       acc_valid_in,
  input  logic       fulln_from_fifo,
  output logic       dma_grant,
  output logic       acc_grant,
  output logic       src_sel,
  output logic       data_valid_to_fifo,
  output logic       busy,
  output logic [2:0] state_o,
  output logic       timeout_err,
  input  logic       err_clr
);

  localparam logic [2:0] c_st_idle      = 3'd0;
  localparam logic [2:0] c_st_dma_act   = 3'd1;
  localparam logic [2:0] c_st_sw_acc    = 3'd2;
  localparam logic [2:0] c_st_acc_act   = 3'd3;
  localparam logic [2:0] c_st_acc_drain = 3'd4;
  localparam logic [2:0] c_st_sw_dma    = 3'd5;

  localparam logic [7:0] c_settle_ld = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] c_drain_ld  = 8'(DRAIN_CYCLES - 1);

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       w_timeout;

  logic       r_dma_grant;
  logic       r_acc_grant;
  logic       r_src_sel;
  logic       r_busy;
  logic       w_dma_grant_nxt;
  logic       w_acc_grant_nxt;
  logic       w_src_sel_nxt;
  logic       w_busy_nxt;

  // State, dwell counter and registered outputs; reset drops everything at once
  always_ff @(posedge acc_clk or negedge acc_rstn) begin
    if (!acc_rstn) begin
      r_state     <= c_st_idle;
      r_cnt       <= 8'd0;
      r_dma_grant <= 1'b0;
      r_acc_grant <= 1'b0;
      r_src_sel   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_dma_grant <= w_dma_grant_nxt;
      r_acc_grant <= w_acc_grant_nxt;
      r_src_sel   <= w_src_sel_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Next state and counter: load on entry to a timed state, count down to 0
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (acc_req) begin
          w_state_nxt = c_st_sw_acc;
        end else if (dma_req) begin
          w_state_nxt = c_st_dma_act;
        end
      end
      c_st_dma_act: begin
        if (dma_done || !dma_req) begin
          w_state_nxt = c_st_idle;
        end
      end
      c_st_sw_acc: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = c_st_acc_act;
        end
      end
      c_st_acc_act: begin
        // Dropping acc_req is a done; the watchdog forces the same exit
        if (acc_done || !acc_req || w_timeout) begin
          w_state_nxt = c_st_acc_drain;
        end
      end
      c_st_acc_drain: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = c_st_sw_dma;
        end
      end
      c_st_sw_dma: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = c_st_idle;
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase

    w_cnt_nxt = r_cnt;
    if (w_state_nxt != r_state) begin
      case (w_state_nxt)
        c_st_sw_acc:    w_cnt_nxt = c_settle_ld;
        c_st_sw_dma:    w_cnt_nxt = c_settle_ld;
        c_st_acc_drain: w_cnt_nxt = c_drain_ld;
        default:        w_cnt_nxt = 8'd0;
      endcase
    end else if (r_cnt != 8'd0) begin
      w_cnt_nxt = r_cnt - 8'd1;
    end
  end

  // Output decode from the upcoming state so outputs register with the state
  always_comb begin
    w_dma_grant_nxt = 1'b0;
    w_acc_grant_nxt = 1'b0;
    w_src_sel_nxt   = 1'b0;
    w_busy_nxt      = (w_state_nxt != c_st_idle);
    case (w_state_nxt)
      c_st_dma_act:   w_dma_grant_nxt = 1'b1;
      c_st_sw_acc:    w_src_sel_nxt   = 1'b1;
      c_st_acc_act: begin
        w_src_sel_nxt   = 1'b1;
        w_acc_grant_nxt = 1'b1;
      end
      c_st_acc_drain: w_src_sel_nxt   = 1'b1;
      default: begin
        w_dma_grant_nxt = 1'b0;
      end
    endcase
  end

  assign dma_grant          = r_dma_grant;
  assign acc_grant          = r_acc_grant;
  assign src_sel            = r_src_sel;
  assign busy               = r_busy;
  assign state_o            = r_state;
  // Only the write enable is combinational; acc_grant confines it to ACC_ACT
  assign data_valid_to_fifo = acc_valid_in & r_acc_grant & fulln_from_fifo;

`ifdef DAC_SRC_CTRL_TIMEOUT_EN
  localparam logic [15:0] c_to_last = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_wdog;
  logic        r_timeout_err;

  // r_wdog holds the number of completed cycles spent in ACC_ACT
  assign w_timeout = (r_state == c_st_acc_act) && (r_wdog == c_to_last);

  // Watchdog counts while ACC_ACT persists, clears on any other state
  always_ff @(posedge acc_clk or negedge acc_rstn) begin
    if (!acc_rstn) begin
      r_wdog <= 16'd0;
    end else if ((r_state == c_st_acc_act) && (w_state_nxt == c_st_acc_act)) begin
      r_wdog <= r_wdog + 16'd1;
    end else begin
      r_wdog <= 16'd0;
    end
  end

  // Sticky error flag; a new timeout outranks a simultaneous clear
  always_ff @(posedge acc_clk or negedge acc_rstn) begin
    if (!acc_rstn) begin
      r_timeout_err <= 1'b0;
    end else if (w_timeout) begin
      r_timeout_err <= 1'b1;
    end else if (err_clr) begin
      r_timeout_err <= 1'b0;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  logic [16:0] w_unused_cfg;

  assign w_timeout    = 1'b0;
  assign timeout_err  = 1'b0;
  assign w_unused_cfg = {err_clr, 16'(TIMEOUT_CYCLES)};
`endif

endmodule
`default_nettype wire

// File: tb/tb_dac_src_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_src_ctrl
// Description : Directed and randomized bench for dac_src_ctrl against a
//               timestamp-based model of the ownership phases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_src_ctrl;

  localparam int SETTLE = 8;
  localparam int DRAIN  = 32;
`ifdef DAC_SRC_CTRL_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 65535;
`endif

  // phase numbers are the externally visible state_o values
  localparam int P_IDLE = 0, P_DMA = 1, P_SETTLE = 2, P_ACC = 3, P_DRAIN = 4, P_BACK = 5;

  logic       acc_clk = 1'b0;
  logic       acc_rstn = 1'b1;
  logic       dma_req = 1'b0, dma_done = 1'b0, acc_req = 1'b0, acc_done = 1'b0;
  logic       acc_valid_in = 1'b0, fulln_from_fifo = 1'b0, err_clr = 1'b0;
  logic       dma_grant, acc_grant, src_sel, data_valid_to_fifo, busy, timeout_err;
  logic [2:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  // model: current phase, edge count, edge at which the phase was entered
  int m_phase = P_IDLE;
  int m_cyc   = 0;
  int m_t0    = 0;
  bit m_err   = 1'b0;

  dac_src_ctrl #(
    .SETTLE_CYCLES (SETTLE),
    .DRAIN_CYCLES  (DRAIN),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .acc_clk           (acc_clk),
    .acc_rstn          (acc_rstn),
    .dma_req           (dma_req),
    .dma_done          (dma_done),
    .acc_req           (acc_req),
    .acc_done          (acc_done),
    .acc_valid_in      (acc_valid_in),
    .fulln_from_fifo   (fulln_from_fifo),
    .dma_grant         (dma_grant),
    .acc_grant         (acc_grant),
    .src_sel           (src_sel),
    .data_valid_to_fifo(data_valid_to_fifo),
    .busy              (busy),
    .state_o           (state_o),
    .timeout_err       (timeout_err),
    .err_clr           (err_clr)
  );

  always #5 acc_clk = ~acc_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("state_o", 32'(state_o), 32'(m_phase));
    check("dma_grant", 32'(dma_grant), 32'(m_phase == P_DMA));
    check("acc_grant", 32'(acc_grant), 32'(m_phase == P_ACC));
    check("src_sel", 32'(src_sel),
          32'(m_phase == P_SETTLE || m_phase == P_ACC || m_phase == P_DRAIN));
    check("busy", 32'(busy), 32'(m_phase != P_IDLE));
    check("timeout_err", 32'(timeout_err), 32'(m_err));
    check("data_valid", 32'(data_valid_to_fifo),
          32'(acc_valid_in && fulln_from_fifo && (m_phase == P_ACC)));
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_t0    = m_cyc;
    m_err   = 1'b0;
  endtask

  // One clock: model decides from inputs held before the edge, then compare
  task automatic step();
    int nxt;
    int elapsed;
    bit to;
    nxt     = m_phase;
    elapsed = m_cyc + 1 - m_t0;
    to      = 1'b0;
    case (m_phase)
      P_IDLE:   if (acc_req) nxt = P_SETTLE; else if (dma_req) nxt = P_DMA;
      P_DMA:    if (dma_done || !dma_req) nxt = P_IDLE;
      P_SETTLE: if (elapsed == SETTLE) nxt = P_ACC;
      P_ACC: begin
        if (acc_done || !acc_req) nxt = P_DRAIN;
`ifdef DAC_SRC_CTRL_TIMEOUT_EN
        if (elapsed == TO) begin
          nxt = P_DRAIN;
          to  = 1'b1;
        end
`endif
      end
      P_DRAIN:  if (elapsed == DRAIN) nxt = P_BACK;
      P_BACK:   if (elapsed == SETTLE) nxt = P_IDLE;
      default:  nxt = P_IDLE;
    endcase
`ifdef DAC_SRC_CTRL_TIMEOUT_EN
    if (to) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
`endif
    @(posedge acc_clk);
    #1;
    m_cyc++;
    if (nxt != m_phase) m_t0 = m_cyc;
    m_phase = nxt;
    check_all();
  endtask

  task automatic pulse_acc_done();
    acc_done = 1'b1;
    step();
    acc_done = 1'b0;
  endtask

  initial begin
    int k_grant, k_src, k_idle, k_to;

    // Reset asserted asynchronously, away from any clock edge
    #1 acc_rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge acc_clk);
    #1;
    check_all();
    acc_rstn = 1'b1;
    step();
    step();
    check("idle_after_reset", 32'(state_o), 32'(P_IDLE));

    // Simultaneous requests: accelerator wins, DMA never granted
    dma_req = 1'b1;
    acc_req = 1'b1;
    step();
    check("simul_state", 32'(state_o), 32'(P_SETTLE));
    check("simul_dma_grant", 32'(dma_grant), 32'd0);
    check("settle_src_cycle1", 32'(src_sel), 32'd1);
    k_grant = -1;
    for (int i = 2; i <= 20 && k_grant < 0; i++) begin
      step();
      if (acc_grant) k_grant = i;
    end
    check("settle_grant_cycle", 32'(k_grant), 32'd9);

    // Write gating follows fulln while granted; stray dma_done ignored
    acc_valid_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fulln_from_fifo = i[0];
      dma_done = (i == 3);
      step();
      check("gate_follow", 32'(data_valid_to_fifo), 32'(i[0]));
    end
    dma_done = 1'b0;

    // Drain timing measured from the acc_done cycle
    acc_req  = 1'b0;
    acc_done = 1'b1;
    k_src    = -1;
    k_idle   = -1;
    for (int i = 1; i <= 60 && k_idle < 0; i++) begin
      step();
      acc_done = 1'b0;
      if (!src_sel && k_src < 0) k_src = i;
      if (state_o == 3'd0 && k_idle < 0) k_idle = i;
    end
    check("drain_src_fall", 32'(k_src), 32'd33);
    check("drain_idle", 32'(k_idle), 32'd41);
    check("gate_off_idle", 32'(data_valid_to_fifo), 32'd0);

    // dma_req still high: DMA phase; acc_req must not preempt it
    step();
    check("dma_entered", 32'(dma_grant), 32'd1);
    acc_req = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("no_preempt", 32'(state_o), 32'(P_DMA));
    dma_done = 1'b1;
    step();
    dma_done = 1'b0;
    check("dma_done_idle", 32'(state_o), 32'(P_IDLE));
    step();
    check("acc_after_dma", 32'(state_o), 32'(P_SETTLE));
    dma_req = 1'b0;

    // Reset in the middle of a drain drops src_sel without a clock edge
    for (int i = 0; i < 10; i++) step();
    pulse_acc_done();
    for (int i = 0; i < 5; i++) step();
    check("in_drain", 32'(state_o), 32'(P_DRAIN));
    #3 acc_rstn = 1'b0;
    #1;
    check("rst_src_sel", 32'(src_sel), 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    model_reset();
    check_all();
    acc_req = 1'b0;
    @(posedge acc_clk);
    #1;
    check_all();
    acc_rstn = 1'b1;
    step();

`ifdef DAC_SRC_CTRL_TIMEOUT_EN
    // Watchdog: hold acc_req with no done
    acc_req = 1'b1;
    for (int i = 0; i < 20 && state_o != 3'(P_ACC); i++) step();
    k_to = -1;
    for (int i = 1; i <= 200 && k_to < 0; i++) begin
      step();
      if (state_o == 3'(P_DRAIN)) k_to = i;
    end
    check("wdog_cycles", 32'(k_to), 32'(TO));
    acc_req = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("wdog_sticky", 32'(timeout_err), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("wdog_clear", 32'(timeout_err), 32'd0);
`else
    k_to = 0;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("no_wdog_err", 32'(timeout_err), 32'(k_to));
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) acc_req = ~acc_req;
      if ($urandom_range(0, 11) == 0) dma_req = ~dma_req;
      acc_done        = ($urandom_range(0, 29) == 0);
      dma_done        = ($urandom_range(0, 19) == 0);
      acc_valid_in    = 1'($urandom_range(0, 1));
      fulln_from_fifo = 1'($urandom_range(0, 1));
      err_clr         = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dac_src_ctrl.md
DAC_SRC_CTRL -- requirements
Module: dac_src_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 8: cycles between src_sel rising and acc_grant; legal range 7..255.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 32: cycles src_sel is held after acc_done; legal range 1..255.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535: ACC_ACTIVE watchdog limit, used only under REQ-029.
REQ-004 SHALL have ports, in this order:
- acc_clk  in  1  single clock; all logic on its rising edge.
- acc_rstn  in  1  reset, asynchronous, active-low.
- dma_req  in  1  DMA path requests the DAC.
- dma_done  in  1  single-cycle pulse: DMA burst finished.
- acc_req  in  1  accelerator requests the DAC.
- acc_done  in  1  single-cycle pulse: accelerator finished writing.
- acc_valid_in  in  1  accelerator sample valid.
- fulln_from_fifo  in  1  accelerator FIFO not full.
- dma_grant  out  1  DMA path owns the DAC.
- acc_grant  out  1  accelerator may write.
- src_sel  out  1  source select to the DAC interface; 1 = accelerator.
- data_valid_to_fifo  out  1  gated write enable.
- busy  out  1  high in any state other than IDLE.
- state_o  out  3  current state encoding.
- timeout_err  out  1  sticky watchdog flag.
- err_clr  in  1  clears timeout_err.

Function
REQ-005 SHALL implement six states, encoded as shown: IDLE=0, DMA_ACT=1, SW_ACC=2, ACC_ACT=3, ACC_DRAIN=4, SW_DMA=5.
REQ-006 IDLE: if acc_req=1, go to SW_ACC; else if dma_req=1, go to DMA_ACT; acc_req SHALL win when both are high.
REQ-007 DMA_ACT: dma_grant=1 and src_sel=0; on dma_done, or on dma_req falling, go to IDLE.
REQ-008 acc_req arriving during DMA_ACT SHALL NOT preempt; it is served after the return to IDLE.
REQ-009 SW_ACC: src_sel=1, acc_grant=0; the 8-bit counter is loaded with SETTLE_CYCLES-1 on entry and decrements; at 0, go to ACC_ACT.
REQ-010 In SW_ACC, acc_grant SHALL first assert exactly SETTLE_CYCLES cycles after src_sel first asserts.
REQ-011 ACC_ACT: src_sel=1, acc_grant=1; on acc_done, go to ACC_DRAIN.
REQ-012 acc_req deasserting in ACC_ACT without acc_done SHALL be treated as acc_done.
REQ-013 ACC_DRAIN: src_sel=1, acc_grant=0; the counter is loaded with DRAIN_CYCLES-1 and decrements; at 0, go to SW_DMA.
REQ-014 SW_DMA: src_sel=0, all grants 0; the counter is loaded with SETTLE_CYCLES-1; at 0, go to IDLE.
REQ-015 The SW_DMA guard SHALL cover the 7-stage stretch of the downstream synchronizer.
REQ-016 data_valid_to_fifo SHALL equal acc_valid_in AND acc_grant AND fulln_from_fifo, combinationally.
REQ-017 No sample SHALL be written outside ACC_ACT.
REQ-018 dma_grant and acc_grant SHALL never be high in the same cycle.
REQ-019 dma_grant and acc_grant SHALL never be high while src_sel disagrees with the grant.
REQ-020 All outputs except data_valid_to_fifo SHALL be registered.
REQ-021 Every state transition SHALL take effect one cycle after its triggering input is sampled.
REQ-022 The counter SHALL be 8 bits and SHALL not wrap below 0.
REQ-023 A counter value of 0 at state entry SHALL mean a one-cycle dwell.
REQ-024 done pulses arriving in states where they are not expected SHALL be ignored.

Reset
REQ-025 acc_rstn=0 SHALL, asynchronously, force state to IDLE and the counter to 0.
REQ-026 acc_rstn=0 SHALL, asynchronously, force dma_grant, acc_grant, src_sel, busy and timeout_err to 0, and state_o to 0.
REQ-027 Reset asserted mid-operation, in any state, SHALL drop src_sel to 0 immediately, with no drain.
REQ-028 After reset release, the first transition SHALL occur no earlier than the first rising edge of acc_clk.

Configuration
REQ-029 With DAC_SRC_CTRL_TIMEOUT_EN defined, a 16-bit watchdog SHALL count cycles spent in ACC_ACT.
REQ-030 With DAC_SRC_CTRL_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL force a transition to ACC_DRAIN and set timeout_err.
REQ-031 With DAC_SRC_CTRL_TIMEOUT_EN defined, timeout_err SHALL remain set until err_clr=1; err_clr and a new timeout in the same cycle SHALL leave timeout_err set.
REQ-032 With DAC_SRC_CTRL_TIMEOUT_EN undefined, no watchdog logic SHALL exist, timeout_err SHALL be tied 0, and err_clr SHALL be ignored.

Verification
REQ-033 Simultaneous requests: dma_req=1 and acc_req=1 in IDLE -> state goes to SW_ACC; dma_grant stays 0.
REQ-034 Settle timing: acc_req=1 with SETTLE_CYCLES=8 -> src_sel rises at cycle 1; acc_grant rises at cycle 9.
REQ-035 Drain timing: acc_done, DRAIN_CYCLES=32 -> src_sel falls 33 cycles later; state reaches IDLE 8 cycles after that.
REQ-036 Write gating: acc_valid_in=1 with fulln_from_fifo toggling during ACC_ACT -> data_valid_to_fifo follows fulln_from_fifo exactly, and is 0 in all other states.
REQ-037 Reset mid-drain: acc_rstn=0 during ACC_DRAIN -> src_sel=0 and state_o=0 in the same cycle, without waiting for a clock edge.
REQ-038 Watchdog (macro defined, TIMEOUT_CYCLES=100): acc_req held with no acc_done -> ACC_DRAIN entered after 100 cycles of ACC_ACT; timeout_err=1 until err_clr.
